// File: rtl/pool_stream_engine_if.sv
// Control, activation-read and packed-output stream signals of pool_stream_engine.
// The master modport is the engine side; slave is the surrounding datapath/SRAM side.
interface pool_stream_engine_if #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned IN_H  = 16,
    parameter int unsigned IN_WD = 16,
    parameter int unsigned LANES = 4
);
    localparam int unsigned RW = $clog2(IN_H);
    localparam int unsigned CW = $clog2(IN_WD);

    logic                     start;
    logic [1:0]               pool_type;
    logic [2:0]               pool_stride;
    logic [2:0]               pool_kernel;
    logic                     busy;
    logic                     done;
    logic                     cfg_err;
    logic                     act_rd_en;
    logic [RW-1:0]            act_rd_row;
    logic [CW-1:0]            act_rd_col;
    logic [IN_W-1:0]          act_rd_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*OUT_W-1:0]   out_data;
    logic [RW-1:0]            out_row;
    logic [CW-1:0]            out_col;

    modport master (
        input  start, pool_type, pool_stride, pool_kernel, act_rd_data, out_ready,
        output busy, done, cfg_err, act_rd_en, act_rd_row, act_rd_col,
        output out_valid, out_data, out_row, out_col
    );

    modport slave (
        output start, pool_type, pool_stride, pool_kernel, act_rd_data, out_ready,
        input  busy, done, cfg_err, act_rd_en, act_rd_row, act_rd_col,
        input  out_valid, out_data, out_row, out_col
    );
endinterface

// File: rtl/pool_stream_engine.sv
// Walks a stored activation frame through a 1-cycle read port, applies NONE/MAX/AVG pooling,
// saturates and packs LANES results per word, and streams words out on valid/ready.
module pool_stream_engine #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned IN_H  = 16,
    parameter int unsigned IN_WD = 16,
    parameter int unsigned LANES = 4,
    parameter int unsigned MAX_K = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    pool_stream_engine_if.master io_bus
);
    localparam int unsigned RW = $clog2(IN_H);
    localparam int unsigned CW = $clog2(IN_WD);
    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned SW = IN_W + 4;
    localparam int unsigned DW = LANES * OUT_W;
    localparam logic [SW-1:0] SAT = {{(SW-OUT_W){1'b0}}, {OUT_W{1'b1}}};
    localparam logic [1:0] T_NONE = 2'd0;
    localparam logic [1:0] T_MAX  = 2'd1;
    localparam logic [1:0] T_AVG  = 2'd2;
    localparam logic [1:0] T_BAD  = 2'd3;

    typedef enum logic [2:0] {StIdle, StAccum, StPack, StEmit, StDone} state_t;

    state_t          r_state;
    logic [2:0]      r_k, r_s, r_kr, r_kc;
    logic [1:0]      r_type;
    logic [RW-1:0]   r_r, r_rd_row, r_out_row;
    logic [CW-1:0]   r_c, r_word_col, r_rd_col, r_out_col;
    logic [LW-1:0]   r_lane;
    logic [5:0]      r_idx;
    logic            r_pend, r_busy, r_done, r_cfg_err, r_rd_en, r_out_valid;
    logic [SW-1:0]   r_acc;
    logic [DW-1:0]   r_word, r_out_data;

    logic [2:0]      w_k_eff, w_s_eff, w_nkr, w_nkc, w_shift;
    logic            w_cfg_bad, w_last_read, w_last_col, w_last_row, w_pack_emit, w_go_next;
    logic [5:0]      w_kk;
    logic [RW-1:0]   w_adv_r;
    logic [CW-1:0]   w_adv_c;
    logic [31:0]     w_acc_row, w_acc_col, w_win_row, w_win_col;
    logic [SW-1:0]   w_din, w_res;
    logic [OUT_W-1:0] w_lane_val;
    logic [DW-1:0]   w_word_next;

    function automatic logic [31:0] f_coord(input logic [31:0] pos, input logic [2:0] s,
                                            input logic [2:0] k);
        return pos * {29'd0, s} + {29'd0, k};
    endfunction

    always_comb begin
        w_k_eff = (io_bus.pool_type == T_NONE) ? 3'd1 : io_bus.pool_kernel;
        w_s_eff = (io_bus.pool_type == T_NONE) ? 3'd1 : io_bus.pool_stride;
        w_cfg_bad = (io_bus.pool_type == T_BAD) || (w_s_eff == 3'd0) || (w_k_eff == 3'd0) ||
                    (32'(w_k_eff) > MAX_K) || (32'(w_k_eff) > IN_H) || (32'(w_k_eff) > IN_WD) ||
                    ((io_bus.pool_type == T_AVG) && (w_k_eff == 3'd3));
        w_kk        = {3'd0, r_k} * {3'd0, r_k};
        w_last_read = (r_idx == w_kk - 6'd1);
        w_nkc       = (r_kc == r_k - 3'd1) ? 3'd0 : r_kc + 3'd1;
        w_nkr       = (r_kc == r_k - 3'd1) ? r_kr + 3'd1 : r_kr;
        // A window is the last in its row/column when the next one would not fit.
        w_last_col  = f_coord(32'(r_c) + 32'd1, r_s, r_k) > IN_WD;
        w_last_row  = f_coord(32'(r_r) + 32'd1, r_s, r_k) > IN_H;
        w_adv_r     = w_last_col ? r_r + 1'b1 : r_r;
        w_adv_c     = w_last_col ? '0 : r_c + 1'b1;
        w_acc_row   = f_coord(32'(r_r), r_s, w_nkr);
        w_acc_col   = f_coord(32'(r_c), r_s, w_nkc);
        w_win_row   = f_coord(32'(w_adv_r), r_s, 3'd0);
        w_win_col   = f_coord(32'(w_adv_c), r_s, 3'd0);
        w_din       = {4'd0, io_bus.act_rd_data};
        case (r_k)
            3'd2:    w_shift = 3'd2;
            3'd3:    w_shift = 3'd3;
            3'd4:    w_shift = 3'd4;
            3'd5:    w_shift = 3'd4;
            3'd6:    w_shift = 3'd5;
            3'd7:    w_shift = 3'd5;
            default: w_shift = 3'd0;
        endcase
        w_res       = (r_type == T_AVG) ? (r_acc >> w_shift) : r_acc;
        w_lane_val  = (w_res > SAT) ? {OUT_W{1'b1}} : w_res[OUT_W-1:0];
        w_word_next = r_word;
        w_word_next[r_lane*OUT_W +: OUT_W] = w_lane_val;
        w_pack_emit = (r_lane == LW'(LANES - 1)) || w_last_col;
        w_go_next   = ((r_state == StPack) && !w_pack_emit) ||
                      ((r_state == StEmit) && io_bus.out_ready && !(w_last_row && w_last_col));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
            r_k <= '0; r_s <= '0; r_kr <= '0; r_kc <= '0; r_type <= '0;
            r_r <= '0; r_c <= '0; r_word_col <= '0; r_lane <= '0; r_idx <= '0;
            r_pend <= 1'b0; r_acc <= '0; r_word <= '0;
            r_busy <= 1'b0; r_done <= 1'b0; r_cfg_err <= 1'b0; r_rd_en <= 1'b0;
            r_rd_row <= '0; r_rd_col <= '0;
            r_out_valid <= 1'b0; r_out_data <= '0; r_out_row <= '0; r_out_col <= '0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (io_bus.start) begin
                        if (w_cfg_bad) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_k <= w_k_eff; r_s <= w_s_eff; r_type <= io_bus.pool_type;
                            r_r <= '0; r_c <= '0; r_lane <= '0; r_word <= '0;
                            r_kr <= '0; r_kc <= '0; r_idx <= '0; r_acc <= '0; r_pend <= 1'b0;
                            r_rd_en <= 1'b1; r_rd_row <= '0; r_rd_col <= '0;
                            r_busy <= 1'b1;
                            r_state <= StAccum;
                        end
                    end
                end
                StAccum: begin
                    // Data for the read issued last cycle arrives now.
                    r_pend <= r_rd_en;
                    if (r_pend) begin
                        if (r_type == T_MAX) begin
                            if (w_din > r_acc) r_acc <= w_din;
                        end else begin
                            r_acc <= r_acc + w_din;
                        end
                    end
                    if (r_rd_en) begin
                        if (w_last_read) begin
                            r_rd_en <= 1'b0;
                        end else begin
                            r_kr <= w_nkr; r_kc <= w_nkc; r_idx <= r_idx + 6'd1;
                            r_rd_row <= w_acc_row[RW-1:0];
                            r_rd_col <= w_acc_col[CW-1:0];
                        end
                    end
                    if (r_pend && !r_rd_en) r_state <= StPack;
                end
                StPack: begin
                    r_word <= w_word_next;
                    if (r_lane == '0) r_word_col <= r_c;
                    if (w_pack_emit) begin
                        r_word      <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_word_next;
                        r_out_row   <= r_r;
                        r_out_col   <= (r_lane == '0) ? r_c : r_word_col;
                        r_state     <= StEmit;
                    end else begin
                        r_lane <= r_lane + 1'b1;
                    end
                end
                StEmit: begin
                    if (io_bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_lane      <= '0;
                        if (w_last_row && w_last_col) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= StDone;
                        end
                    end
                end
                StDone:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
            if (w_go_next) begin
                r_r <= w_adv_r; r_c <= w_adv_c;
                r_kr <= '0; r_kc <= '0; r_idx <= '0; r_acc <= '0; r_pend <= 1'b0;
                r_rd_en  <= 1'b1;
                r_rd_row <= w_win_row[RW-1:0];
                r_rd_col <= w_win_col[CW-1:0];
                r_state  <= StAccum;
            end
        end
    end

    assign io_bus.busy       = r_busy;
    assign io_bus.done       = r_done;
    assign io_bus.cfg_err    = r_cfg_err;
    assign io_bus.act_rd_en  = r_rd_en;
    assign io_bus.act_rd_row = r_rd_row;
    assign io_bus.act_rd_col = r_rd_col;
    assign io_bus.out_valid  = r_out_valid;
    assign io_bus.out_data   = r_out_data;
    assign io_bus.out_row    = r_out_row;
    assign io_bus.out_col    = r_out_col;
endmodule

// File: tb/tb_pool_stream_engine.sv
// Directed bench for pool_stream_engine on a 4x4 frame with a behavioural pooling model
// feeding an expected-word queue.
module tb_pool_stream_engine;
    localparam int unsigned IN_W  = 16;
    localparam int unsigned OUT_W = 8;
    localparam int unsigned IN_H  = 4;
    localparam int unsigned IN_WD = 4;
    localparam int unsigned LANES = 4;
    localparam int unsigned MAX_K = 4;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  row;
        logic [1:0]  col;
    } word_t;

    logic  clock = 1'b0;
    logic  reset = 1'b1;
    word_t exp_q[$];
    int    mem[4][4];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    n_reads = 0;
    int    n_viol = 0;

    always #5 clock = ~clock;

    pool_stream_engine_if #(
        .IN_W(IN_W), .OUT_W(OUT_W), .IN_H(IN_H), .IN_WD(IN_WD), .LANES(LANES)
    ) bus ();

    pool_stream_engine #(
        .IN_W(IN_W), .OUT_W(OUT_W), .IN_H(IN_H), .IN_WD(IN_WD), .LANES(LANES), .MAX_K(MAX_K)
    ) dut (
        .clock (clock),
        .reset (reset),
        .io_bus(bus)
    );

    // Activation buffer: data valid one cycle after the request, junk otherwise.
    always @(posedge clock) begin
        if (bus.act_rd_en) bus.act_rd_data <= 16'(mem[bus.act_rd_row][bus.act_rd_col]);
        else               bus.act_rd_data <= 16'hBEEF;
        if (!reset && bus.act_rd_en) n_reads <= n_reads + 1;
        if (!reset && bus.act_rd_en && bus.out_valid) n_viol <= n_viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic init_mem();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) mem[r][c] = 4 * r + c;
    endtask

    task automatic push_expected(input int ptype, input int k, input int s);
        int oh, ow, v, sum, lane;
        logic [31:0] word;
        word_t w;
        if (ptype == 0) begin k = 1; s = 1; end
        oh = (int'(IN_H) - k) / s + 1;
        ow = (int'(IN_WD) - k) / s + 1;
        for (int r = 0; r < oh; r++) begin
            word = '0;
            for (int c = 0; c < ow; c++) begin
                v = 0; sum = 0;
                for (int kr = 0; kr < k; kr++)
                    for (int kc = 0; kc < k; kc++) begin
                        if (mem[r*s+kr][c*s+kc] > v) v = mem[r*s+kr][c*s+kc];
                        sum += mem[r*s+kr][c*s+kc];
                    end
                if (ptype == 2) v = sum / (k * k);
                if (v > 255) v = 255;
                lane = c % int'(LANES);
                word[lane*8 +: 8] = 8'(v);
                if (lane == int'(LANES) - 1 || c == ow - 1) begin
                    w.data = word; w.row = 2'(r); w.col = 2'(c - lane);
                    exp_q.push_back(w);
                    word = '0;
                end
            end
        end
    endtask

    task automatic run_frame(input string name, input int ptype, input int k, input int s,
                             input int hold, input int poke_at, output int first_valid);
        int cyc, held, done_cnt, err_cnt;
        bit fin;
        word_t w;
        cyc = 0; held = hold; done_cnt = 0; err_cnt = 0; fin = 0; first_valid = -1;
        @(negedge clock);
        bus.start = 1'b1; bus.pool_type = 2'(ptype);
        bus.pool_kernel = 3'(k); bus.pool_stride = 3'(s);
        bus.out_ready = (hold == 0);
        while (!fin && cyc < 2000) begin
            @(negedge clock);
            cyc++;
            bus.start = 1'b0;
            if (cyc == poke_at) begin
                bus.start = 1'b1; bus.pool_type = 2'd3;
                bus.pool_kernel = 3'd0; bus.pool_stride = 3'd0;
            end
            if (cyc == 1) chk({name, " busy"}, 32'(bus.busy), 32'd1);
            if (bus.cfg_err) err_cnt++;
            if (bus.done) begin done_cnt++; fin = 1; end
            if (bus.out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                chk({name, " word expected"}, 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    if (held > 0) begin
                        bus.out_ready = 1'b0;
                        held--;
                        chk({name, " hold data"}, bus.out_data, exp_q[0].data);
                        chk({name, " hold no read"}, 32'(bus.act_rd_en), 32'd0);
                    end else begin
                        bus.out_ready = 1'b1;
                        w = exp_q.pop_front();
                        chk({name, " data"}, bus.out_data, w.data);
                        chk({name, " row"}, 32'(bus.out_row), 32'(w.row));
                        chk({name, " col"}, 32'(bus.out_col), 32'(w.col));
                    end
                end
            end else begin
                bus.out_ready = (held == 0);
            end
        end
        chk({name, " finished"}, 32'(fin), 32'd1);
        @(negedge clock);
        chk({name, " done single"}, 32'(bus.done), 32'd0);
        chk({name, " busy after"}, 32'(bus.busy), 32'd0);
        chk({name, " words left"}, 32'(exp_q.size()), 32'd0);
        chk({name, " cfg_err"}, 32'(err_cnt), 32'd0);
        exp_q.delete();
        bus.out_ready = 1'b1;
    endtask

    task automatic cfg_bad(input string name, input int ptype, input int k, input int s);
        int reads0;
        @(negedge clock);
        bus.start = 1'b1; bus.pool_type = 2'(ptype);
        bus.pool_kernel = 3'(k); bus.pool_stride = 3'(s);
        reads0 = n_reads;
        @(negedge clock);
        bus.start = 1'b0;
        chk({name, " cfg_err"}, 32'(bus.cfg_err), 32'd1);
        chk({name, " busy"}, 32'(bus.busy), 32'd0);
        @(negedge clock);
        chk({name, " cfg_err pulse"}, 32'(bus.cfg_err), 32'd0);
        chk({name, " idle"}, 32'(bus.busy), 32'd0);
        chk({name, " no reads"}, 32'(n_reads), 32'(reads0));
    endtask

    initial begin
        int fv, reads0;
        bit hit;
        bus.start = 1'b0; bus.pool_type = '0; bus.pool_kernel = '0; bus.pool_stride = '0;
        bus.out_ready = 1'b1;
        init_mem();
        repeat (3) @(negedge clock);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst cfg_err", 32'(bus.cfg_err), 32'd0);
        chk("rst rd_en", 32'(bus.act_rd_en), 32'd0);
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst out_data", bus.out_data, 32'd0);
        chk("rst out_row", 32'(bus.out_row), 32'd0);
        chk("rst out_col", 32'(bus.out_col), 32'd0);
        reset = 1'b0;

        reads0 = n_reads;
        push_expected(1, 2, 2);
        run_frame("max_k2s2", 1, 2, 2, 0, 0, fv);
        chk("max_k2s2 reads", 32'(n_reads - reads0), 32'd16);

        reads0 = n_reads;
        push_expected(2, 2, 2);
        run_frame("avg_k2s2", 2, 2, 2, 0, 0, fv);
        chk("avg_k2s2 first word cycle", 32'(fv), 32'(2 * (2 * 2 + 1 + 1) + 1));
        chk("avg_k2s2 reads", 32'(n_reads - reads0), 32'd16);

        mem[0][0] = 255; mem[0][1] = 300;
        reads0 = n_reads;
        push_expected(0, 1, 1);
        run_frame("none", 0, 3, 2, 0, 0, fv);
        chk("none reads", 32'(n_reads - reads0), 32'd16);
        init_mem();

        push_expected(1, 3, 1);
        run_frame("max_k3s1_hold", 1, 3, 1, 5, 0, fv);

        cfg_bad("avg_k3", 2, 3, 1);
        cfg_bad("type3", 3, 2, 2);
        cfg_bad("stride0", 1, 2, 0);

        push_expected(1, 2, 2);
        run_frame("start_busy", 1, 2, 2, 0, 3, fv);

        @(negedge clock);
        bus.start = 1'b1; bus.pool_type = 2'd1; bus.pool_kernel = 3'd2; bus.pool_stride = 3'd2;
        reads0 = n_reads;
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clock);
            bus.start = 1'b0;
            if (n_reads - reads0 >= 6) hit = 1;
        end
        chk("abort reached 2nd output", 32'(hit), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort rd_en", 32'(bus.act_rd_en), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        repeat (3) begin
            @(negedge clock);
            chk("abort no done", 32'(bus.done), 32'd0);
        end
        push_expected(2, 2, 2);
        run_frame("after_abort", 2, 2, 2, 0, 0, fv);

        chk("no reads during emit", 32'(n_viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pool_stream_engine.md
Name: pool_stream_engine

Overview:
- Sequential, parametrised pooling unit that sits between the activation-function output buffer and the output SRAM.
- Walks a stored activation frame through a 1-cycle-latency read port and computes NONE, MAX or AVG pooling with runtime kernel and stride.
- Saturates each result to the SRAM word width, packs LANES results per word and streams the words out over a valid/ready handshake.

Parameters:
- IN_W, 16, activation input width (unsigned).
- OUT_W, 8, pooled output width per lane.
- IN_H, 16, activation frame height.
- IN_WD, 16, activation frame width.
- LANES, 4, outputs packed per SRAM word.
- MAX_K, 4, largest supported kernel size.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- pool_type  in  2  0=NONE, 1=MAX, 2=AVG, 3=illegal.
- pool_stride  in  3  stride S.
- pool_kernel  in  3  kernel K.
- busy  out  1  high from accepted start until DONE.
- done  out  1  one-cycle pulse after the last word is accepted.
- cfg_err  out  1  one-cycle pulse when start carries an illegal config.
- act_rd_en  out  1  activation read request.
- act_rd_row  out  clog2(IN_H)  read row.
- act_rd_col  out  clog2(IN_WD)  read column.
- act_rd_data  in  IN_W  read data, valid exactly 1 cycle after act_rd_en.
- out_valid  out  1  packed word valid.
- out_ready  in  1  SRAM accepts word.
- out_data  out  LANES*OUT_W  lane i at bits [i*OUT_W +: OUT_W].
- out_row  out  clog2(IN_H)  pooled row of the word.
- out_col  out  clog2(IN_WD)  pooled column of lane 0.

Behaviour:
- Reset values: busy, done, cfg_err, act_rd_en, out_valid = 0; out_data, out_row, out_col = 0. FSM goes to IDLE.
- Reset mid-operation aborts the frame: in-flight reads and the partial word are dropped, and done does not pulse.
- Config is latched on an accepted start. start is ignored when not in IDLE.
- NONE forces K=1, S=1 regardless of the pool_kernel and pool_stride inputs.
- Illegal config (any of the following): S=0, K=0, K>MAX_K, K>IN_H, K>IN_WD, pool_type=3, or AVG with K=3. Response: cfg_err pulses the next cycle, the FSM stays in IDLE and busy stays 0.
- Output dimensions: OH=(IN_H-K)/S+1, OW=(IN_WD-K)/S+1, integer floor. Windows are never partial.
- FSM states IDLE, ACCUM, PACK, EMIT, DONE.
  - IDLE -> ACCUM on a legal start.
  - ACCUM issues K*K reads, one per cycle, row-major within the window at (r*S+kr, c*S+kc). Accumulation consumes data 1 cycle later, so ACCUM occupies K*K+1 cycles per output.
  - MAX: accumulator starts at 0 and updates on strict greater-than.
  - AVG: IN_W+4 bit sum, then right shift by log2(K*K); truncates.
  - NONE: passthrough.
- PACK (1 cycle):
  - Result saturates to 2^OUT_W-1 if above that value, else takes the low OUT_W bits.
  - Result is written to lane (c mod LANES).
  - Go to EMIT if the lane is LANES-1 or c=OW-1; else go to ACCUM for the next c.
- EMIT:
  - out_valid is held with out_data, out_row, out_col stable until out_ready.
  - No reads are issued during EMIT.
  - Unused lanes of a row-end word are 0.
  - On handshake: go to DONE if r=OH-1 and c=OW-1; else go to ACCUM. c wraps to 0 and r increments at row end.
- A handshake in the first cycle of EMIT is legal: out_valid is high for 1 cycle.
- DONE: done=1 for one cycle, busy drops in the same cycle, then IDLE.
- A start asserted in the DONE cycle is ignored.
- Words are emitted in raster order: row ascending, then lane-0 column ascending.

Test Plan:
- IN_H=IN_WD=4, LANES=4, act[r][c]=4r+c; MAX K=2 S=2 -> 2 words: row0 lanes {5,7,0,0} out_col 0; row1 {13,15,0,0}. done pulses once; no cfg_err.
- Same frame, AVG K=2 S=2 -> row0 {2,4,0,0}, row1 {10,12,0,0} (truncated averages). Each output takes 5 ACCUM cycles: 4 reads + 1 drain.
- NONE with act[0][1]=300 and act[0][0]=255 (other values r*4+c) -> word0 lanes {255,255,2,3}; the 300 saturates to 255. 4 words total; out_col 0 on each.
- MAX K=3 S=1 on 4x4 -> OH=OW=2. Hold out_ready=0 for 5 cycles on the first word: out_valid stays 1, out_data stays {10,11,0,0}, act_rd_en stays 0; completes after ready rises.
- Illegal configs:
  - AVG K=3 -> cfg_err pulse, busy=0, no reads.
  - pool_type=3 -> cfg_err.
  - S=0 -> cfg_err.
  - start while busy -> no effect on the running frame.
- Reset asserted mid-ACCUM of the second output -> next cycle: busy=0, out_valid=0, act_rd_en=0, no done. A fresh start then yields a correct full frame.
